junction_light_ctrl: RTL and testbench
======================================

Name: junction_light_ctrl

Overview:
- Two-road traffic junction controller that sequences the main-road and side-road signal heads.
- Decides which road holds green, times green, yellow and all-red phases, and arbitrates the side-road car sensor against main-road priority.
- Moore machine: outputs depend only on the current state.
- Uses the team light encoding: red=3'b100, green=3'b010, yellow=3'b001, bit order [0:2].

Parameters:
- MAIN_MIN, 8, minimum main-road green cycles before yielding (1..255).
- SIDE_GREEN, 5, fixed side-road green cycles (1..255).
- YELLOW_T, 3, yellow cycles for either road (1..255).
- ALLRED_T, 2, all-red clearance cycles (1..255).
- WALK_T, 4, pedestrian walk cycles, used only with the optional feature (1..255).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  reset. One clock; reset is synchronous and active-low.
- side_car  input  1  side-road vehicle sensor, level, sampled on posedge.
- ped_btn  input  1  pedestrian request, sampled on posedge; ignored without the feature.
- main_light  output  3 [0:2]  main-road signal head.
- side_light  output  3 [0:2]  side-road signal head.
- walk  output  1  pedestrian walk lamp.

Behaviour:
- States:
  - S_MG: main green, side red.
  - S_MY: main yellow, side red.
  - S_AR1: all red.
  - S_SG: main red, side green.
  - S_SY: main red, side yellow.
  - S_AR2: all red.
  - S_WALK: all red, walk=1; feature only.
- Outputs are decoded combinationally from the state register, so they change on the same edge as the state.
- Illegal state encodings decode to all red and recover to S_AR2 on the next edge.
- Timer: 8-bit. Cleared to 0 on every state entry, +1 per cycle while in the state. In S_MG it saturates at 255 and never wraps.
- Phase length rule: a state entered at edge k and left at edge k+T has lasted T cycles. The exit condition is timer==T-1.
- Transitions:
  - S_MG -> S_MY when timer>=MAIN_MIN-1 and side_pend=1. Otherwise hold indefinitely.
  - S_MY -> S_AR1 at timer==YELLOW_T-1.
  - S_AR1 -> S_SG at timer==ALLRED_T-1.
  - S_SG -> S_SY at timer==SIDE_GREEN-1.
  - S_SY -> S_AR2 at timer==YELLOW_T-1.
  - S_AR2 -> S_MG at timer==ALLRED_T-1.
- side_pend latch:
  - Set on any edge with side_car=1 while not in S_SG.
  - Cleared on the edge that enters S_SG.
  - If set and cleared on the same edge, clear wins.
  - side_car during S_SG is ignored. side_car during S_SY or S_AR2 is latched and served after the next MAIN_MIN.
- Single-cycle side_car pulses must be latched; pending state is never lost.
- Reset (rst_n=0 at an edge, including mid-phase):
  - state=S_AR2, timer=0, side_pend=0, ped_pend=0.
  - Outputs main_light=100, side_light=100, walk=0 from that edge.
  - After release, main green appears ALLRED_T cycles later.
- No green is ever shown to both roads. Every green-to-other-green change passes through yellow and all-red.

Optional Feature:
- Macro: JUNCTION_PED_WALK_EN.
- Defined:
  - ped_pend latch is set by ped_btn=1 in any state except S_WALK, and cleared on entry to S_WALK.
  - S_MG exit condition becomes timer>=MAIN_MIN-1 and (side_pend or ped_pend).
  - S_AR1 at timer==ALLRED_T-1 goes to S_WALK if ped_pend=1, else to S_SG.
  - S_WALK at timer==WALK_T-1 goes to S_SG if side_pend=1, else to S_AR2.
  - walk=1 only in S_WALK.
- Not defined:
  - ped_btn is unused; walk is tied to 0.
  - No S_WALK state or ped_pend register is built.
  - Port list is unchanged.

Test Plan:
- Reset, default parameters: rst_n=0 for 2 cycles then 1, no requests -> 2 cycles main=100/side=100, then main=010/side=100, held for 300 cycles (timer saturation, no wrap).
- Single-cycle side_car pulse at MG timer=2 -> MG lasts 8 cycles total, MY 3 (main=001), AR1 2, SG 5 (side=010), SY 3 (side=001), AR2 2, then MG; side_pend=0 after SG entry.
- side_car held high for the whole cycle -> SG still exactly 5 cycles; after return to MG, the next yield occurs after exactly 8 MG cycles because of re-latch during SY/AR2.
- rst_n=0 on SG cycle 3 -> next edge all red, walk=0, side_pend=0; after release, 2 cycles all red then MG with no side service.
- Invariant check over a 10k-cycle random side_car run: main_light and side_light are never both 010 or 001; every light value is one-hot.
- JUNCTION_PED_WALK_EN defined, ped_btn pulse in MG, side_car=0 -> MG 8, MY 3, AR1 2, WALK 4 cycles (walk=1, both 100), AR2 2, MG; with side_car also pending -> WALK is followed by SG 5.

Source files
------------

// File: rtl/junction_light_ctrl.sv
// Two-road junction light controller: Moore FSM with phase timer and side-road request latch.
// Optional pedestrian walk phase is built only when JUNCTION_PED_WALK_EN is defined.
module junction_light_ctrl #(
  parameter int unsigned MAIN_MIN   = 8,
  parameter int unsigned SIDE_GREEN = 5,
  parameter int unsigned YELLOW_T   = 3,
  parameter int unsigned ALLRED_T   = 2,
  parameter int unsigned WALK_T     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       side_car,
  input  logic       ped_btn,
  output logic [0:2] main_light,
  output logic [0:2] side_light,
  output logic       walk
);

  localparam logic [2:0] S_MG   = 3'd0;
  localparam logic [2:0] S_MY   = 3'd1;
  localparam logic [2:0] S_AR1  = 3'd2;
  localparam logic [2:0] S_SG   = 3'd3;
  localparam logic [2:0] S_SY   = 3'd4;
  localparam logic [2:0] S_AR2  = 3'd5;
  localparam logic [2:0] S_WALK = 3'd6;

  localparam logic [0:2] RED    = 3'b100;
  localparam logic [0:2] GREEN  = 3'b010;
  localparam logic [0:2] YELLOW = 3'b001;

  // Exit compares use timer == T-1 so a phase lasts exactly T cycles.
  localparam logic [7:0] MG_LAST = 8'(MAIN_MIN - 1);
  localparam logic [7:0] SG_LAST = 8'(SIDE_GREEN - 1);
  localparam logic [7:0] YL_LAST = 8'(YELLOW_T - 1);
  localparam logic [7:0] AR_LAST = 8'(ALLRED_T - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       side_pend_q, side_pend_d;
  logic       ped_req;

`ifdef JUNCTION_PED_WALK_EN
  localparam logic [7:0] WK_LAST = 8'(WALK_T - 1);

  logic ped_pend_q, ped_pend_d;

  assign ped_req = ped_pend_q;

  always_comb begin
    ped_pend_d = ped_pend_q;
    if (ped_btn && state_q != S_WALK) ped_pend_d = 1'b1;
    if (state_d == S_WALK && state_q != S_WALK) ped_pend_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ped_pend_q <= 1'b0;
    else        ped_pend_q <= ped_pend_d;
  end
`else
  logic ped_unused;

  assign ped_req    = 1'b0;
  assign ped_unused = ped_btn | (WALK_T == 0);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_MG:  if (timer_q >= MG_LAST && (side_pend_q || ped_req)) state_d = S_MY;
      S_MY:  if (timer_q == YL_LAST) state_d = S_AR1;
`ifdef JUNCTION_PED_WALK_EN
      S_AR1: if (timer_q == AR_LAST) state_d = ped_pend_q ? S_WALK : S_SG;
      S_WALK: if (timer_q == WK_LAST) state_d = side_pend_q ? S_SG : S_AR2;
`else
      S_AR1: if (timer_q == AR_LAST) state_d = S_SG;
`endif
      S_SG:  if (timer_q == SG_LAST) state_d = S_SY;
      S_SY:  if (timer_q == YL_LAST) state_d = S_AR1 + 3'd3;
      S_AR2: if (timer_q == AR_LAST) state_d = S_MG;
      default: state_d = S_AR2;
    endcase
  end

  // Timer restarts on every state change and saturates rather than wrapping.
  always_comb begin
    if (state_d != state_q)   timer_d = '0;
    else if (timer_q == '1)   timer_d = timer_q;
    else                      timer_d = timer_q + 8'd1;
  end

  // Clear on SG entry takes priority over a same-edge set.
  always_comb begin
    side_pend_d = side_pend_q;
    if (side_car && state_q != S_SG) side_pend_d = 1'b1;
    if (state_d == S_SG && state_q != S_SG) side_pend_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_AR2;
      timer_q     <= '0;
      side_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      side_pend_q <= side_pend_d;
    end
  end

  always_comb begin
    main_light = RED;
    side_light = RED;
    walk       = 1'b0;
    case (state_q)
      S_MG: main_light = GREEN;
      S_MY: main_light = YELLOW;
      S_SG: side_light = GREEN;
      S_SY: side_light = YELLOW;
`ifdef JUNCTION_PED_WALK_EN
      S_WALK: walk = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_junction_light_ctrl.sv
// Directed bench for junction_light_ctrl: phase lengths, request latching, reset, invariants.
// Walk-phase steps are compiled only when JUNCTION_PED_WALK_EN is defined.
module tb_junction_light_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       side_car = 1'b0;
  logic       ped_btn = 1'b0;
  logic [0:2] main_light;
  logic [0:2] side_light;
  logic       walk;

  int n_chk  = 0;
  int n_fail = 0;

  // {main_light, side_light, walk}
  localparam logic [6:0] RR = 7'b100_100_0;
  localparam logic [6:0] GR = 7'b010_100_0;
  localparam logic [6:0] YR = 7'b001_100_0;
  localparam logic [6:0] RG = 7'b100_010_0;
  localparam logic [6:0] RY = 7'b100_001_0;
  localparam logic [6:0] WK = 7'b100_100_1;

  junction_light_ctrl #(
    .MAIN_MIN  (8),
    .SIDE_GREEN(5),
    .YELLOW_T  (3),
    .ALLRED_T  (2),
    .WALK_T    (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .side_car  (side_car),
    .ped_btn   (ped_btn),
    .main_light(main_light),
    .side_light(side_light),
    .walk      (walk)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {main_light, side_light, walk};
    n_chk++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
  endtask

  task automatic phase(input string tag, input logic [6:0] exp, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, exp);
      tick();
    end
  endtask

  initial begin
    logic ok;

    // Reset held two edges, then boot through AR2 into main green.
    tick(); chk("rst_hold0", RR);
    tick(); chk("rst_hold1", RR);
    rst_n = 1'b1;
    phase("boot_ar2", RR, 2);
    phase("mg_hold", GR, 300);

    // Single-cycle side_car pulse at MG timer=2.
    rst_n = 1'b0; tick(); chk("rst_again", RR); rst_n = 1'b1;
    phase("p_boot_ar2", RR, 2);
    phase("p_mg_a", GR, 2);
    side_car = 1'b1; chk("p_mg_pulse", GR); tick(); side_car = 1'b0;
    phase("p_mg_b", GR, 5);
    phase("p_my", YR, 3);
    phase("p_ar1", RR, 2);
    phase("p_sg", RG, 5);
    phase("p_sy", RY, 3);
    phase("p_ar2", RR, 2);
    phase("p_mg_idle", GR, 20);

`ifndef JUNCTION_PED_WALK_EN
    ped_btn = 1'b1; chk("ped_ignored0", GR); tick(); ped_btn = 1'b0;
    phase("ped_ignored", GR, 15);
`endif

    // side_car held high: SG stays 5, re-latch during SY/AR2 forces a yield after 8 MG cycles.
    side_car = 1'b1;
    phase("h_mg", GR, 2);
    phase("h_my", YR, 3);
    phase("h_ar1", RR, 2);
    phase("h_sg", RG, 5);
    phase("h_sy", RY, 3);
    phase("h_ar2", RR, 2);
    phase("h_mg2", GR, 8);
    chk("h_my2_first", YR); side_car = 1'b0; tick();
    phase("h_my2", YR, 2);
    phase("h_ar1b", RR, 2);
    phase("h_sg2", RG, 2);

    // Reset during SG cycle 3, with side_car asserted on the reset edge.
    chk("r_sg3", RG);
    rst_n = 1'b0; side_car = 1'b1; tick();
    chk("r_reset", RR);
    rst_n = 1'b1; side_car = 1'b0;
    phase("r_ar2", RR, 2);
    phase("r_mg_no_side", GR, 20);

`ifdef JUNCTION_PED_WALK_EN
    // Pedestrian request alone: walk phase then back to main.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    phase("w_boot", RR, 2);
    phase("w_mg_a", GR, 2);
    ped_btn = 1'b1; chk("w_mg_pulse", GR); tick(); ped_btn = 1'b0;
    phase("w_mg_b", GR, 5);
    phase("w_my", YR, 3);
    phase("w_ar1", RR, 2);
    phase("w_walk", WK, 4);
    phase("w_ar2", RR, 2);
    phase("w_mg_idle", GR, 20);

    // Pedestrian and side both pending: walk is followed by side green.
    side_car = 1'b1; ped_btn = 1'b1; chk("ws_mg_pulse", GR); tick();
    side_car = 1'b0; ped_btn = 1'b0;
    phase("ws_mg", GR, 1);
    phase("ws_my", YR, 3);
    phase("ws_ar1", RR, 2);
    phase("ws_walk", WK, 4);
    phase("ws_sg", RG, 5);
    phase("ws_sy", RY, 3);
    phase("ws_ar2", RR, 2);
    phase("ws_mg_idle", GR, 10);
`endif

    // Random traffic: lights one-hot, never both non-red, walk only with all red.
    for (int i = 0; i < 10000; i++) begin
      side_car = 1'($urandom_range(0, 1));
      ped_btn  = ($urandom_range(0, 15) == 0);
      ok = $onehot(main_light) && $onehot(side_light)
           && !(main_light != 3'b100 && side_light != 3'b100)
           && (!walk || (main_light == 3'b100 && side_light == 3'b100));
      n_chk++;
      assert (ok === 1'b1)
        else begin
          n_fail++;
          $error("FAIL invariant: observed main=%b side=%b walk=%b expected one-hot, no shared go", main_light, side_light, walk);
        end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
